// File: rtl/adc_scan_seq_if.sv
// adc_scan_seq_if: Avalon-MM slave port (control, status and result reads) of the ADC scan sequencer
interface adc_scan_seq_if;
  logic [9:0]  address;
  logic        write;
  logic        read;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  modport master(output address, write, read, writedata, input readdata, readdatavalid, waitrequest);
  modport slave(input address, write, read, writedata, output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/adc_scan_seq.sv
// adc_scan_seq: autonomous multi-channel scan sequencer for the MAX10 hard ADC with per-channel result registers
// Define ADC_SCAN_AVG_EN to convert each channel 4 times and store the averaged result.
module adc_scan_seq #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int NUM_CH = 16
) (
  input  logic              clk,
  input  logic              reset,
  adc_scan_seq_if.slave     bus,
  output logic [4:0]        adc_chsel,
  output logic              adc_soc,
  input  logic              adc_eoc,
  input  logic [11:0]       adc_dout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, SEL, START, CONV, RELEASE} state_t;
  state_t state_q, state_d;
  logic run_q, run_d, cont_q, cont_d, done_q, done_d, tmo_q, tmo_d;
  logic first_q, first_d, soc_q, soc_d, rdv_q, rdv_d, wait_q, sync0_q, sync1_q;
  logic [NUM_CH-1:0] mask_q, mask_d, new_q, new_d;
  logic [11:0] res_q [NUM_CH];
  logic [11:0] res_d [NUM_CH];
  logic [15:0] scancnt_q, scancnt_d, rdata_q, rdata_d, rmux;
  logic [3:0] ch_q, ch_d, above_ch, low_ch, sel_ch, idx;
  logic [4:0] chsel_q, chsel_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic above_ok, pass_end, bus_ok, wr, rd, res_hit, eoc_rise;
`ifdef ADC_SCAN_AVG_EN
  logic [13:0] acc_q, acc_d, sum;
  logic [1:0] cnt_q, cnt_d;
  assign sum = acc_q + {2'b00, adc_dout};
`endif
  assign bus_ok   = ~wait_q;
  assign wr       = bus.write & bus_ok;
  assign rd       = bus.read & bus_ok;
  assign idx      = bus.address[3:0];
  assign res_hit  = (bus.address[9:4] == 6'd1) && (int'(idx) < NUM_CH);
  assign eoc_rise = sync0_q & ~sync1_q;
  assign pass_end = ~first_q & ~above_ok;
  assign sel_ch   = (first_q || !above_ok) ? low_ch : above_ch;
  // Downward scan leaves the lowest qualifying bit in each result.
  always_comb begin
    above_ok = 1'b0;
    above_ch = '0;
    low_ch   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) low_ch = 4'(i);
      if (mask_q[i] && 4'(i) > ch_q) begin
        above_ok = 1'b1;
        above_ch = 4'(i);
      end
    end
  end
  always_comb begin
    rmux = (bus.address == 10'd0) ? {14'd0, cont_q, run_q} :
           (bus.address == 10'd1) ? 16'(mask_q) :
           (bus.address == 10'd2) ? {13'd0, tmo_q, done_q, state_q != IDLE} :
           (bus.address == 10'd3) ? scancnt_q :
           res_hit ? {new_q[idx], 3'd0, res_q[idx]} : 16'h0;
  end
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    cont_d    = cont_q;
    done_d    = done_q;
    tmo_d     = tmo_q;
    first_d   = first_q;
    soc_d     = soc_q;
    mask_d    = mask_q;
    new_d     = new_q;
    res_d     = res_q;
    scancnt_d = scancnt_q;
    ch_d      = ch_q;
    chsel_d   = chsel_q;
    tcnt_d    = tcnt_q;
`ifdef ADC_SCAN_AVG_EN
    acc_d     = acc_q;
    cnt_d     = cnt_q;
`endif
    if (wr && bus.address == 10'd2) begin
      done_d = done_q & ~bus.writedata[1];
      tmo_d  = tmo_q & ~bus.writedata[2];
    end
    // Read-clear goes first so a same-cycle capture leaves NEW set.
    if (rd && res_hit) new_d[idx] = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_q && mask_q == '0) run_d = 1'b0;
        else if (run_q) begin
          state_d = SEL;
          first_d = 1'b1;
        end
      end
      SEL: begin
        first_d = 1'b0;
        state_d = START;
        if (mask_q == '0) begin
          run_d   = 1'b0;
          state_d = IDLE;
        end else if (pass_end && !cont_q) begin
          scancnt_d = scancnt_q + 16'd1;
          done_d    = 1'b1;
          run_d     = 1'b0;
          state_d   = IDLE;
        end else begin
          scancnt_d = pass_end ? scancnt_q + 16'd1 : scancnt_q;
          ch_d      = sel_ch;
          chsel_d   = {1'b0, sel_ch};
`ifdef ADC_SCAN_AVG_EN
          acc_d     = '0;
          cnt_d     = '0;
`endif
        end
      end
      START: begin
        soc_d   = 1'b1;
        tcnt_d  = '0;
        state_d = CONV;
      end
      CONV: begin
        if (eoc_rise) begin
          soc_d   = 1'b0;
          state_d = RELEASE;
`ifdef ADC_SCAN_AVG_EN
          acc_d   = sum;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            res_d[ch_q] = sum[13:2];
            new_d[ch_q] = 1'b1;
          end
`else
          res_d[ch_q] = adc_dout;
          new_d[ch_q] = 1'b1;
`endif
        end else if (tcnt_q == TMAX) begin
          soc_d   = 1'b0;
          tmo_d   = 1'b1;
          run_d   = 1'b0;
          state_d = RELEASE;
`ifdef ADC_SCAN_AVG_EN
          acc_d   = '0;
          cnt_d   = '0;
`endif
        end else tcnt_d = tcnt_q + 1'b1;
      end
      RELEASE: begin
`ifdef ADC_SCAN_AVG_EN
        if (!sync1_q) state_d = !run_q ? IDLE : (cnt_q != 2'd0) ? START : SEL;
`else
        if (!sync1_q) state_d = run_q ? SEL : IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (wr && bus.address == 10'd0) begin
      run_d  = bus.writedata[0];
      cont_d = bus.writedata[1];
    end
    if (wr && bus.address == 10'd1) mask_d = bus.writedata[NUM_CH-1:0];
    rdata_d = rd ? rmux : 16'h0;
    rdv_d   = rd;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      cont_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      first_q   <= 1'b0;
      soc_q     <= 1'b0;
      mask_q    <= '0;
      new_q     <= '0;
      res_q     <= '{default: '0};
      scancnt_q <= '0;
      ch_q      <= '0;
      chsel_q   <= '0;
      tcnt_q    <= '0;
      rdata_q   <= '0;
      rdv_q     <= 1'b0;
      wait_q    <= 1'b1;
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      cont_q    <= cont_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      first_q   <= first_d;
      soc_q     <= soc_d;
      mask_q    <= mask_d;
      new_q     <= new_d;
      res_q     <= res_d;
      scancnt_q <= scancnt_d;
      ch_q      <= ch_d;
      chsel_q   <= chsel_d;
      tcnt_q    <= tcnt_d;
      rdata_q   <= rdata_d;
      rdv_q     <= rdv_d;
      wait_q    <= 1'b0;
      sync0_q   <= adc_eoc;
      sync1_q   <= sync0_q;
`ifdef ADC_SCAN_AVG_EN
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
`endif
    end
  end
  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rdv_q;
  assign bus.waitrequest   = wait_q;
  assign adc_chsel         = chsel_q;
  assign adc_soc           = soc_q;
endmodule

// File: tb/tb_adc_scan_seq.sv
// tb_adc_scan_seq: directed bench for adc_scan_seq with a hand-driven ADC model and a 16-cycle timeout
module tb_adc_scan_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic adc_eoc = 1'b0;
  logic [11:0] adc_dout = '0;
  logic [4:0] adc_chsel;
  logic adc_soc;
  logic [4:0] ch;
  int checks = 0;
  int failures = 0;
  adc_scan_seq_if bus();
  adc_scan_seq #(.TIMEOUT_CYCLES(16), .NUM_CH(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .adc_chsel(adc_chsel),
    .adc_soc(adc_soc),
    .adc_eoc(adc_eoc),
    .adc_dout(adc_dout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [9:0] a, input logic [15:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask
  task automatic rdchk(input string tag, input logic [9:0] a, input logic [15:0] exp);
    bus.address = a;
    bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    check(tag, bus.readdata, exp);
  endtask
  task automatic wait_soc(input logic lvl);
    int n = 0;
    while (adc_soc !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("soc_wait", adc_soc, lvl);
  endtask
  // Answers one conversion; a negative val returns 0x100 + channel.
  task automatic serve(input int val, output logic [4:0] c);
    wait_soc(1'b1);
    c = adc_chsel;
    repeat (2) @(negedge clk);
    adc_dout = (val < 0) ? 12'h100 + 12'(adc_chsel) : 12'(val);
    adc_eoc = 1'b1;
    wait_soc(1'b0);
    adc_eoc = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [9:0] ra [7];
    ra = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd16, 10'd18, 10'd21};
    bus.address = '0;
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.writedata = '0;
    repeat (3) @(negedge clk);
    check("wait_in_rst", bus.waitrequest, 1);
    reset = 1'b1;
    @(negedge clk);
    check("wait_rel", bus.waitrequest, 0);
`ifdef ADC_SCAN_AVG_EN
    wr(10'd1, 16'h0008);
    wr(10'd0, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      serve(16'h10 + 2 * i, ch);
      check("avg_ch", ch, 3);
    end
    repeat (8) @(negedge clk);
    check("avg_no_5th_soc", adc_soc, 0);
    rdchk("avg_res3", 10'd19, 16'h8013);
    rdchk("avg_status", 10'd2, 16'h0002);
    rdchk("avg_cnt", 10'd3, 16'h0001);
`else
    wr(10'd1, 16'h0025);
    wr(10'd0, 16'h0001);
    serve(-1, ch); check("sp_ch0", ch, 0);
    serve(-1, ch); check("sp_ch1", ch, 2);
    serve(-1, ch); check("sp_ch2", ch, 5);
    repeat (8) @(negedge clk);
    rdchk("sp_res0", 10'd16, 16'h8100);
    rdchk("sp_res2", 10'd18, 16'h8102);
    rdchk("sp_res5", 10'd21, 16'h8105);
    rdchk("sp_res0_clr", 10'd16, 16'h0100);
    rdchk("sp_status", 10'd2, 16'h0002);
    rdchk("sp_cnt", 10'd3, 16'h0001);
    rdchk("sp_ctrl", 10'd0, 16'h0000);
    rdchk("unmapped", 10'h100, 16'h0000);
    rdchk("res1", 10'd17, 16'h0000);
    bus.address = 10'd1;
    bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    check("rdv_hi", bus.readdatavalid, 1);
    check("rd_mask", bus.readdata, 16'h0025);
    @(negedge clk);
    check("rdv_lo", bus.readdatavalid, 0);
    wr(10'd2, 16'h0002);
    wr(10'd1, 16'h8001);
    wr(10'd0, 16'h0003);
    serve(-1, ch); check("cc_ch0", ch, 0);
    serve(-1, ch); check("cc_ch1", ch, 15);
    serve(-1, ch); check("cc_ch2", ch, 0);
    rdchk("cc_cnt", 10'd3, 16'h0002);
    serve(-1, ch); check("cc_ch3", ch, 15);
    wait_soc(1'b1);
    wr(10'd0, 16'h0000);
    serve(12'h0AB, ch); check("cc_ch4", ch, 0);
    repeat (8) @(negedge clk);
    rdchk("cc_res0", 10'd16, 16'h80AB);
    rdchk("cc_cnt2", 10'd3, 16'h0003);
    rdchk("cc_status", 10'd2, 16'h0000);
    wr(10'd1, 16'h0004);
    wr(10'd0, 16'h0001);
    wait_soc(1'b1);
    repeat (15) @(negedge clk);
    check("to_soc_hi", adc_soc, 1);
    @(negedge clk);
    check("to_soc_lo", adc_soc, 0);
    repeat (2) @(negedge clk);
    rdchk("to_status", 10'd2, 16'h0004);
    rdchk("to_ctrl", 10'd0, 16'h0000);
    rdchk("to_res2", 10'd18, 16'h0102);
    wr(10'd2, 16'h0004);
    rdchk("to_clr", 10'd2, 16'h0000);
    wr(10'd0, 16'h0001);
    wait_soc(1'b1);
    repeat (2) @(negedge clk);
    adc_dout = 12'h0CD;
    adc_eoc = 1'b1;
    @(negedge clk);
    bus.address = 10'd18;
    bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    check("race_old", bus.readdata, 16'h0102);
    check("race_soc", adc_soc, 0);
    adc_eoc = 1'b0;
    repeat (8) @(negedge clk);
    rdchk("race_new", 10'd18, 16'h80CD);
    rdchk("race_cnt", 10'd3, 16'h0004);
    rdchk("race_status", 10'd2, 16'h0002);
    wr(10'd1, 16'h0001);
    wr(10'd0, 16'h0001);
    wait_soc(1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_soc", adc_soc, 0);
    check("rst_wait", bus.waitrequest, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_wait_rel", bus.waitrequest, 0);
    for (int i = 0; i < 7; i++) rdchk("rst_reg", ra[i], 16'h0000);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
